// File: rtl/core_types_pkg.sv
// Shared execution-cluster types: RV32I ALU op encodings, default PRF geometry
// and the helper that sizes PRF bank/port index fields.
package core_types_pkg;

  // {funct7[5], funct3}
  localparam logic [3:0] ALUOP_ADD  = 4'b0000;
  localparam logic [3:0] ALUOP_SUB  = 4'b1000;
  localparam logic [3:0] ALUOP_SLL  = 4'b0001;
  localparam logic [3:0] ALUOP_SLT  = 4'b0010;
  localparam logic [3:0] ALUOP_SLTU = 4'b0011;
  localparam logic [3:0] ALUOP_XOR  = 4'b0100;
  localparam logic [3:0] ALUOP_SRL  = 4'b0101;
  localparam logic [3:0] ALUOP_SRA  = 4'b1101;
  localparam logic [3:0] ALUOP_OR   = 4'b0110;
  localparam logic [3:0] ALUOP_AND  = 4'b0111;

  localparam int unsigned PRF_BANK_COUNT_DEF = 4;
  localparam int unsigned PRF_READ_PORTS_DEF = 2;

  // Width of a bank or read-port index; never narrower than one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] sext_imm12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational RV32I integer ALU shared by the ALU pipelines.
module alu_core
  import core_types_pkg::*;
(
  input  logic [3:0]  op,
  input  logic        is_reg,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result
);

  logic [2:0] funct3;
  logic       alt;
  logic [3:0] eff_op;
  logic [4:0] shamt;

  assign funct3 = op[2:0];
  // op[3] picks SUB only in reg mode; SRA/SRAI honour it in both modes
  assign alt    = op[3] & ((is_reg & (funct3 == 3'b000)) | (funct3 == 3'b101));
  assign eff_op = {alt, funct3};
  assign shamt  = B[4:0];

  // Evaluate the decoded operation
  always_comb begin
    result = '0;
    case (eff_op)
      ALUOP_ADD:  result = A + B;
      ALUOP_SUB:  result = A - B;
      ALUOP_SLL:  result = A << shamt;
      ALUOP_SLT:  result = {31'b0, $signed(A) < $signed(B)};
      ALUOP_SLTU: result = {31'b0, A < B};
      ALUOP_XOR:  result = A ^ B;
      ALUOP_SRL:  result = A >> shamt;
      ALUOP_SRA:  result = $signed(A) >>> shamt;
      ALUOP_OR:   result = A | B;
      ALUOP_AND:  result = A & B;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipeline.sv
// Two-stage (operand collect, writeback) reg-reg / reg-imm ALU pipeline.
module alu_pipeline
  import core_types_pkg::*;
#(
  parameter int unsigned PRF_BANK_COUNT  = PRF_BANK_COUNT_DEF,
  parameter int unsigned PRF_READ_PORTS  = PRF_READ_PORTS_DEF,
  parameter int unsigned LOG_PR_COUNT    = 7,
  parameter int unsigned LOG_ROB_ENTRIES = 7
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  input  logic                                    issue_valid,
  input  logic                                    issue_is_reg,
  input  logic [3:0]                              issue_op,
  input  logic [11:0]                             issue_imm12,
  input  logic                                    issue_A_forward,
  input  logic                                    issue_A_is_zero,
  input  logic [idx_width(PRF_BANK_COUNT)-1:0]    issue_A_bank,
  input  logic                                    issue_B_forward,
  input  logic                                    issue_B_is_zero,
  input  logic [idx_width(PRF_BANK_COUNT)-1:0]    issue_B_bank,
  input  logic [LOG_PR_COUNT-1:0]                 issue_dest_PR,
  input  logic [LOG_ROB_ENTRIES-1:0]              issue_ROB_index,
  output logic                                    issue_ready,
  input  logic                                    A_reg_read_ack,
  input  logic [idx_width(PRF_READ_PORTS)-1:0]    A_reg_read_port,
  input  logic                                    B_reg_read_ack,
  input  logic [idx_width(PRF_READ_PORTS)-1:0]    B_reg_read_port,
  input  logic [PRF_BANK_COUNT-1:0][PRF_READ_PORTS-1:0][31:0] reg_read_data_by_bank_by_port,
  input  logic [PRF_BANK_COUNT-1:0][31:0]         forward_data_by_bank,
  output logic                                    WB_valid,
  output logic [31:0]                             WB_data,
  output logic [LOG_PR_COUNT-1:0]                 WB_PR,
  output logic [LOG_ROB_ENTRIES-1:0]              WB_ROB_index,
  input  logic                                    WB_ready
);

  localparam int unsigned BankW = idx_width(PRF_BANK_COUNT);

  // OC stage
  logic                       oc_valid_q;
  logic                       oc_first_q;
  logic                       oc_is_reg_q;
  logic [3:0]                 oc_op_q;
  logic [11:0]                oc_imm_q;
  logic                       oc_a_fwd_q, oc_a_zero_q, oc_b_fwd_q, oc_b_zero_q;
  logic [BankW-1:0]           oc_a_bank_q, oc_b_bank_q;
  logic [LOG_PR_COUNT-1:0]    oc_dest_q;
  logic [LOG_ROB_ENTRIES-1:0] oc_rob_q;
  logic                       a_saved_q, b_saved_q;
  logic [31:0]                a_buf_q, b_buf_q;

  // WB stage
  logic                       wb_valid_q;
  logic [31:0]                wb_data_q;
  logic [LOG_PR_COUNT-1:0]    wb_pr_q;
  logic [LOG_ROB_ENTRIES-1:0] wb_rob_q;

  logic        a_res, b_res;
  logic [31:0] a_res_data, b_res_data;
  logic [31:0] a_val, b_val, alu_result;
  logic        a_avail, b_avail, launch, issue_fire;

  // Resolve operand A this cycle: zero, then forward (first cycle only), then PRF ack
  always_comb begin
    a_res      = 1'b0;
    a_res_data = '0;
    if (oc_valid_q && !a_saved_q) begin
      if (oc_a_zero_q) begin
        a_res = oc_first_q;
      end else if (oc_a_fwd_q) begin
        a_res      = oc_first_q;
        a_res_data = forward_data_by_bank[oc_a_bank_q];
      end else begin
        a_res      = A_reg_read_ack;
        a_res_data = reg_read_data_by_bank_by_port[oc_a_bank_q][A_reg_read_port];
      end
    end
  end

  // Resolve operand B; in imm mode it is always the sign-extended immediate
  always_comb begin
    b_res      = 1'b0;
    b_res_data = '0;
    if (oc_valid_q && !b_saved_q) begin
      if (!oc_is_reg_q) begin
        b_res      = 1'b1;
        b_res_data = sext_imm12(oc_imm_q);
      end else if (oc_b_zero_q) begin
        b_res = oc_first_q;
      end else if (oc_b_fwd_q) begin
        b_res      = oc_first_q;
        b_res_data = forward_data_by_bank[oc_b_bank_q];
      end else begin
        b_res      = B_reg_read_ack;
        b_res_data = reg_read_data_by_bank_by_port[oc_b_bank_q][B_reg_read_port];
      end
    end
  end

  assign a_avail     = a_saved_q | a_res;
  assign b_avail     = b_saved_q | b_res;
  assign a_val       = a_saved_q ? a_buf_q : a_res_data;
  assign b_val       = b_saved_q ? b_buf_q : b_res_data;
  assign launch      = oc_valid_q & a_avail & b_avail & (~wb_valid_q | WB_ready);
  assign issue_ready = ~oc_valid_q | launch;
  assign issue_fire  = issue_valid & issue_ready;

  alu_core u_alu_core (
    .op     (oc_op_q),
    .is_reg (oc_is_reg_q),
    .A      (a_val),
    .B      (b_val),
    .result (alu_result)
  );

  // OC stage: accept issues, save operands that resolve while the op waits
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      oc_valid_q  <= 1'b0;
      oc_first_q  <= 1'b0;
      oc_is_reg_q <= 1'b0;
      oc_op_q     <= '0;
      oc_imm_q    <= '0;
      oc_a_fwd_q  <= 1'b0;
      oc_a_zero_q <= 1'b0;
      oc_b_fwd_q  <= 1'b0;
      oc_b_zero_q <= 1'b0;
      oc_a_bank_q <= '0;
      oc_b_bank_q <= '0;
      oc_dest_q   <= '0;
      oc_rob_q    <= '0;
      a_saved_q   <= 1'b0;
      b_saved_q   <= 1'b0;
      a_buf_q     <= '0;
      b_buf_q     <= '0;
    end else if (issue_fire) begin
      oc_valid_q  <= 1'b1;
      oc_first_q  <= 1'b1;
      oc_is_reg_q <= issue_is_reg;
      oc_op_q     <= issue_op;
      oc_imm_q    <= issue_imm12;
      oc_a_fwd_q  <= issue_A_forward;
      oc_a_zero_q <= issue_A_is_zero;
      oc_b_fwd_q  <= issue_B_forward;
      oc_b_zero_q <= issue_B_is_zero;
      oc_a_bank_q <= issue_A_bank;
      oc_b_bank_q <= issue_B_bank;
      oc_dest_q   <= issue_dest_PR;
      oc_rob_q    <= issue_ROB_index;
      a_saved_q   <= 1'b0;
      b_saved_q   <= 1'b0;
    end else begin
      oc_first_q <= 1'b0;
      if (launch) begin
        oc_valid_q <= 1'b0;
        a_saved_q  <= 1'b0;
        b_saved_q  <= 1'b0;
      end else begin
        if (a_res) begin
          a_saved_q <= 1'b1;
          a_buf_q   <= a_res_data;
        end
        if (b_res) begin
          b_saved_q <= 1'b1;
          b_buf_q   <= b_res_data;
        end
      end
    end
  end

  // WB stage: load on launch, drain on WB_ready; fields hold while stalled
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_pr_q    <= '0;
      wb_rob_q   <= '0;
    end else if (launch) begin
      wb_valid_q <= 1'b1;
      wb_data_q  <= alu_result;
      wb_pr_q    <= oc_dest_q;
      wb_rob_q   <= oc_rob_q;
    end else if (WB_ready) begin
      wb_valid_q <= 1'b0;
    end
  end

  assign WB_valid     = wb_valid_q;
  assign WB_data      = wb_data_q;
  assign WB_PR        = wb_pr_q;
  assign WB_ROB_index = wb_rob_q;

endmodule

// File: tb/tb_alu_pipeline.sv
// Self-checking bench for alu_pipeline: directed scenarios with literal
// expectations, then randomized traffic against a scoreboard model.
module tb_alu_pipeline;

  localparam int NB = 4;
  localparam int NP = 2;
  localparam int LPR = 7;
  localparam int LROB = 7;

  logic CLK = 1'b0;
  logic RST;
  logic issue_valid, issue_is_reg;
  logic [3:0] issue_op;
  logic [11:0] issue_imm12;
  logic issue_A_forward, issue_A_is_zero, issue_B_forward, issue_B_is_zero;
  logic [1:0] issue_A_bank, issue_B_bank;
  logic [LPR-1:0] issue_dest_PR;
  logic [LROB-1:0] issue_ROB_index;
  logic issue_ready;
  logic A_reg_read_ack, B_reg_read_ack;
  logic [0:0] A_reg_read_port, B_reg_read_port;
  logic [NB-1:0][NP-1:0][31:0] rd;
  logic [NB-1:0][31:0] fwd;
  logic WB_valid;
  logic [31:0] WB_data;
  logic [LPR-1:0] WB_PR;
  logic [LROB-1:0] WB_ROB_index;
  logic WB_ready;

  alu_pipeline #(
    .PRF_BANK_COUNT  (NB),
    .PRF_READ_PORTS  (NP),
    .LOG_PR_COUNT    (LPR),
    .LOG_ROB_ENTRIES (LROB)
  ) dut (
    .CLK                           (CLK),
    .RST                           (RST),
    .issue_valid                   (issue_valid),
    .issue_is_reg                  (issue_is_reg),
    .issue_op                      (issue_op),
    .issue_imm12                   (issue_imm12),
    .issue_A_forward               (issue_A_forward),
    .issue_A_is_zero               (issue_A_is_zero),
    .issue_A_bank                  (issue_A_bank),
    .issue_B_forward               (issue_B_forward),
    .issue_B_is_zero               (issue_B_is_zero),
    .issue_B_bank                  (issue_B_bank),
    .issue_dest_PR                 (issue_dest_PR),
    .issue_ROB_index               (issue_ROB_index),
    .issue_ready                   (issue_ready),
    .A_reg_read_ack                (A_reg_read_ack),
    .A_reg_read_port               (A_reg_read_port),
    .B_reg_read_ack                (B_reg_read_ack),
    .B_reg_read_port               (B_reg_read_port),
    .reg_read_data_by_bank_by_port (rd),
    .forward_data_by_bank          (fwd),
    .WB_valid                      (WB_valid),
    .WB_data                       (WB_data),
    .WB_PR                         (WB_PR),
    .WB_ROB_index                  (WB_ROB_index),
    .WB_ready                      (WB_ready)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int wb_seen = 0;
  bit chk_en = 1'b0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    logic [31:0] r;
    r = {{20{imm[11]}}, imm};
    return r;
  endfunction

  // Reference: RV32I semantics from the mnemonic rules, plain integer arithmetic
  function automatic logic [31:0] model_alu(input logic [3:0] op, input bit is_reg,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int unsigned sh;
    longint sa;
    bit alt;
    sh  = int'(b % 32);
    alt = op[3] && (is_reg || op[2:0] == 3'd5);
    sa  = longint'($signed(a));
    case (op[2:0])
      3'd0: r = alt ? a - b : a + b;
      3'd1: r = a << sh;
      3'd2: r = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
      3'd3: r = ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: r = alt ? 32'(sa / (longint'(1) << sh) - ((sa < 0 && (sa % (longint'(1) << sh)) != 0) ? 1 : 0))
                    : a >> sh;
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  task automatic scramble();
    for (int b = 0; b < NB; b++) begin
      fwd[b] = $urandom;
      for (int p = 0; p < NP; p++) rd[b][p] = $urandom;
    end
  endtask

  task automatic set_issue(input bit is_reg, input logic [3:0] op, input logic [11:0] imm,
                           input bit a_fwd, input bit a_zero, input bit b_fwd, input bit b_zero,
                           input logic [1:0] a_bank, input logic [1:0] b_bank,
                           input logic [LPR-1:0] dest, input logic [LROB-1:0] rob);
    issue_valid = 1'b1;
    issue_is_reg = is_reg;
    issue_op = op;
    issue_imm12 = imm;
    issue_A_forward = a_fwd;
    issue_A_is_zero = a_zero;
    issue_B_forward = b_fwd;
    issue_B_is_zero = b_zero;
    issue_A_bank = a_bank;
    issue_B_bank = b_bank;
    issue_dest_PR = dest;
    issue_ROB_index = rob;
  endtask

  // Reg-imm op with A forwarded: result must appear two cycles after issue
  task automatic run_fwd_imm(input string name, input logic [3:0] op, input logic [11:0] imm,
                             input logic [1:0] bank, input logic [31:0] aval,
                             input logic [LPR-1:0] dest, input logic [LROB-1:0] rob,
                             input logic [31:0] exp);
    @(negedge CLK);
    scramble();
    WB_ready = 1'b1;
    set_issue(1'b0, op, imm, 1'b1, 1'b0, 1'b0, 1'b0, bank, 2'd0, dest, rob);
    #1 check({name, "_issue_ready"}, 64'(issue_ready), 64'd1);
    @(negedge CLK);
    issue_valid = 1'b0;
    scramble();
    fwd[bank] = aval;
    #1 check({name, "_not_early"}, 64'(WB_valid), 64'd0);
    @(negedge CLK);
    scramble();
    #1 check({name, "_valid"}, 64'(WB_valid), 64'd1);
    check({name, "_data"}, 64'(WB_data), 64'(exp));
    check({name, "_tags"}, 64'({WB_PR, WB_ROB_index}), 64'({dest, rob}));
  endtask

  // Scoreboard: every accepted writeback must match the model in issue order
  logic [63:0] prev_fields;
  bit prev_stall = 1'b0;
  always @(negedge CLK) begin
    logic [63:0] e;
    #2;
    if (chk_en) begin
      if (prev_stall) begin
        check("wb_hold_valid", 64'(WB_valid), 64'd1);
        check("wb_hold_fields", 64'({WB_data, WB_PR, WB_ROB_index}), prev_fields);
      end
      if (WB_valid && WB_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL wb_unexpected: got writeback data=0x%0h rob=%0d, required none",
                   WB_data, WB_ROB_index);
        end else begin
          e = exp_q.pop_front();
          check("wb_result", 64'({WB_data, WB_PR, WB_ROB_index}), e);
          wb_seen++;
        end
      end
      prev_stall  = WB_valid && !WB_ready;
      prev_fields = 64'({WB_data, WB_PR, WB_ROB_index});
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Random-phase bookkeeping of the op the bench believes is in OC
  bit cur_valid, cur_is_reg;
  int cur_a_mode, cur_b_mode, cur_a_delay, cur_b_delay, cur_age;
  logic [1:0] cur_a_bank, cur_b_bank;
  logic [31:0] cur_a_val, cur_b_val;
  logic [3:0] reg_ops [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                               4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(3))
      0: v = $urandom;
      1: v = $urandom_range(40);
      2: v = 32'h8000_0000 | $urandom_range(7);
      default: v = 32'hFFFF_FFFF - $urandom_range(3);
    endcase
    return v;
  endfunction

  task automatic issue_random();
    logic [3:0] op;
    logic [11:0] imm;
    logic [LPR-1:0] dest;
    logic [LROB-1:0] rob;
    cur_is_reg = 1'($urandom_range(1));
    op   = cur_is_reg ? reg_ops[$urandom_range(9)] : 4'($urandom_range(15));
    imm  = 12'($urandom);
    dest = LPR'($urandom);
    rob  = LROB'($urandom);
    cur_a_mode = $urandom_range(2);
    cur_b_mode = $urandom_range(2);
    cur_a_bank = 2'($urandom_range(3));
    cur_b_bank = 2'($urandom_range(3));
    cur_a_delay = $urandom_range(3);
    cur_b_delay = $urandom_range(3);
    cur_a_val = (cur_a_mode == 0) ? 32'd0 : rand_operand();
    if (!cur_is_reg) cur_b_val = sext12(imm);
    else cur_b_val = (cur_b_mode == 0) ? 32'd0 : rand_operand();
    if (cur_is_reg && cur_a_mode == 1 && cur_b_mode == 1 && cur_a_bank == cur_b_bank)
      cur_b_val = cur_a_val;
    if (cur_is_reg)
      set_issue(1'b1, op, imm, cur_a_mode == 1, cur_a_mode == 0, cur_b_mode == 1,
                cur_b_mode == 0, cur_a_bank, cur_b_bank, dest, rob);
    else
      set_issue(1'b0, op, imm, cur_a_mode == 1, cur_a_mode == 0, 1'($urandom_range(1)),
                1'($urandom_range(1)), cur_a_bank, cur_b_bank, dest, rob);
    exp_q.push_back(64'({model_alu(op, cur_is_reg, cur_a_val, cur_b_val), dest, rob}));
    cur_valid = 1'b1;
    cur_age = 0;
  endtask

  // Drive one random cycle: forward/ack data for the OC op, then maybe a new issue
  task automatic random_cycle(input bit allow_issue);
    logic [0:0] pa;
    bit a_now, b_now;
    @(negedge CLK);
    scramble();
    issue_valid = 1'b0;
    A_reg_read_ack = 1'b0;
    B_reg_read_ack = 1'b0;
    A_reg_read_port = 1'($urandom_range(1));
    B_reg_read_port = 1'($urandom_range(1));
    WB_ready = ($urandom_range(3) != 0);
    if (cur_valid) begin
      if (cur_age == 0) begin
        if (cur_a_mode == 1) fwd[cur_a_bank] = cur_a_val;
        if (cur_is_reg && cur_b_mode == 1) fwd[cur_b_bank] = cur_b_val;
      end
      a_now = (cur_a_mode == 2) && (cur_age == cur_a_delay);
      b_now = cur_is_reg && (cur_b_mode == 2) && (cur_age == cur_b_delay);
      pa = A_reg_read_port;
      if (a_now) begin
        A_reg_read_ack = 1'b1;
        rd[cur_a_bank][pa] = cur_a_val;
      end else if ((cur_a_mode != 2 || cur_age > cur_a_delay) && $urandom_range(3) == 0) begin
        A_reg_read_ack = 1'b1;
      end
      if (b_now) begin
        if (a_now && cur_a_bank == cur_b_bank) B_reg_read_port = ~pa;
        B_reg_read_ack = 1'b1;
        rd[cur_b_bank][B_reg_read_port] = cur_b_val;
      end else if ((!cur_is_reg || cur_b_mode != 2 || cur_age > cur_b_delay) &&
                   $urandom_range(3) == 0) begin
        B_reg_read_ack = 1'b1;
      end
    end else begin
      A_reg_read_ack = 1'($urandom_range(1));
      B_reg_read_ack = 1'($urandom_range(1));
    end
    #1;
    if (cur_valid) begin
      if (issue_ready) cur_valid = 1'b0;
      else cur_age++;
    end
    if (allow_issue && issue_ready && $urandom_range(9) < 7) issue_random();
  endtask

  initial begin
    RST = 1'b1;
    issue_valid = 1'b0;
    set_issue(1'b0, 4'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, '0, '0);
    issue_valid = 1'b1;
    A_reg_read_ack = 1'b1;
    B_reg_read_ack = 1'b1;
    A_reg_read_port = 1'b0;
    B_reg_read_port = 1'b0;
    WB_ready = 1'b0;
    scramble();
    #1;
    check("reset_wb_valid", 64'(WB_valid), 64'd0);
    check("reset_wb_fields", 64'({WB_data, WB_PR, WB_ROB_index}), 64'd0);
    check("reset_issue_ready", 64'(issue_ready), 64'd1);
    @(negedge CLK);
    issue_valid = 1'b0;
    A_reg_read_ack = 1'b0;
    B_reg_read_ack = 1'b0;
    RST = 1'b0;

    // Pin the model against hand-computed values
    check("model_addi", 64'(model_alu(4'b0000, 1'b0, 32'd5, sext12(12'hFFF))), 64'd4);
    check("model_srai", 64'(model_alu(4'b1101, 1'b0, 32'h8000_0000, sext12(12'h41F))),
          64'hFFFF_FFFF);
    check("model_sub", 64'(model_alu(4'b1000, 1'b1, 32'd10, 32'd3)), 64'd7);
    check("model_slt", 64'(model_alu(4'b0010, 1'b1, 32'hFFFF_FFFF, 32'd1)), 64'd1);
    check("model_sltu", 64'(model_alu(4'b0011, 1'b1, 32'hFFFF_FFFF, 32'd1)), 64'd0);
    check("model_sra5", 64'(model_alu(4'b1101, 1'b1, 32'hFFFF_FF81, 32'd5)), 64'hFFFF_FFFC);

    // Reg-imm forwarded-A ops
    run_fwd_imm("addi", 4'b0000, 12'hFFF, 2'd2, 32'd5, 7'd5, 7'd1, 32'd4);
    run_fwd_imm("srai", 4'b1101, 12'h41F, 2'd0, 32'h8000_0000, 7'd6, 7'd2, 32'hFFFF_FFFF);
    run_fwd_imm("srli", 4'b0101, 12'h41F, 2'd0, 32'h8000_0000, 7'd7, 7'd3, 32'd1);
    run_fwd_imm("addi_op8", 4'b1000, 12'h003, 2'd3, 32'd10, 7'd8, 7'd4, 32'd13);

    // Reg-reg SUB: B acked first and saved, A acked two cycles later
    @(negedge CLK);
    scramble();
    WB_ready = 1'b1;
    set_issue(1'b1, 4'b1000, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd3, 7'd9, 7'd2);
    @(negedge CLK);
    issue_valid = 1'b0;
    scramble();
    B_reg_read_ack = 1'b1;
    B_reg_read_port = 1'b0;
    rd[3][0] = 32'd3;
    #1 check("sub_t1_no_wb", 64'(WB_valid), 64'd0);
    @(negedge CLK);
    B_reg_read_ack = 1'b0;
    scramble();
    #1 check("sub_t2_blocked", 64'(issue_ready), 64'd0);
    @(negedge CLK);
    scramble();
    A_reg_read_ack = 1'b1;
    A_reg_read_port = 1'b1;
    rd[1][1] = 32'd10;
    B_reg_read_ack = 1'b1;  // stale ack on the saved B must be ignored
    #1 check("sub_t3_launch", 64'(issue_ready), 64'd1);
    check("sub_t3_no_wb", 64'(WB_valid), 64'd0);
    @(negedge CLK);
    A_reg_read_ack = 1'b0;
    B_reg_read_ack = 1'b0;
    #1 check("sub_t4_valid", 64'(WB_valid), 64'd1);
    check("sub_t4_data", 64'(WB_data), 64'd7);
    check("sub_t4_tags", 64'({WB_PR, WB_ROB_index}), 64'({7'd9, 7'd2}));

    // Backpressure: forwarded A must be saved while WB is stalled
    @(negedge CLK);
    scramble();
    WB_ready = 1'b0;
    set_issue(1'b0, 4'b0000, 12'h011, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 7'd20, 7'd20);
    @(negedge CLK);
    scramble();
    set_issue(1'b0, 4'b0000, 12'h023, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 7'd21, 7'd21);
    #1 check("bp_second_issue", 64'(issue_ready), 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      issue_valid = 1'b0;
      scramble();
      if (c == 0) fwd[1] = 32'h100;
      #1 check("bp_stall_ready", 64'(issue_ready), 64'd0);
      check("bp_stall_wb", 64'({WB_valid, WB_data, WB_PR, WB_ROB_index}),
            64'({1'b1, 32'h11, 7'd20, 7'd20}));
    end
    @(negedge CLK);
    scramble();
    WB_ready = 1'b1;
    #1 check("bp_release_ready", 64'(issue_ready), 64'd1);
    check("bp_release_wb", 64'({WB_valid, WB_data}), 64'({1'b1, 32'h11}));
    @(negedge CLK);
    scramble();
    #1 check("bp_saved_fwd", 64'({WB_valid, WB_data, WB_PR}), 64'({1'b1, 32'h123, 7'd21}));
    @(negedge CLK);
    #1 check("bp_drained", 64'(WB_valid), 64'd0);

    // Back-to-back: 8 zero-operand ops, one per cycle
    for (int k = 0; k <= 10; k++) begin
      @(negedge CLK);
      scramble();
      if (k < 8) set_issue(1'b0, 4'b0000, 12'(k), 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0,
                           LPR'(k + 32), LROB'(k));
      else issue_valid = 1'b0;
      #1;
      if (k < 8) check("b2b_ready", 64'(issue_ready), 64'd1);
      if (k >= 2 && k <= 9)
        check("b2b_wb", 64'({WB_valid, WB_data, WB_ROB_index}), 64'({1'b1, 32'(k - 2), 7'(k - 2)}));
      else
        check("b2b_idle", 64'(WB_valid), 64'd0);
    end

    // Reset with OC and WB occupied; a later stale ack must not write back
    @(negedge CLK);
    scramble();
    WB_ready = 1'b0;
    set_issue(1'b0, 4'b0000, 12'h007, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 7'd40, 7'd40);
    @(negedge CLK);
    set_issue(1'b1, 4'b0000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 7'd41, 7'd41);
    @(negedge CLK);
    issue_valid = 1'b0;
    #1 check("rst_pre_state", 64'({WB_valid, issue_ready}), 64'({1'b1, 1'b0}));
    @(negedge CLK);
    RST = 1'b1;
    #1 check("rst_immediate", 64'({WB_valid, issue_ready}), 64'({1'b0, 1'b1}));
    check("rst_wb_data", 64'(WB_data), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    WB_ready = 1'b1;
    A_reg_read_ack = 1'b1;
    A_reg_read_port = 1'b0;
    rd[2][0] = 32'h55;
    for (int c = 0; c < 4; c++) begin
      #1 check("rst_stale_ack", 64'(WB_valid), 64'd0);
      @(negedge CLK);
      A_reg_read_ack = 1'b0;
    end

    // Random traffic against the scoreboard
    cur_valid = 1'b0;
    chk_en = 1'b1;
    for (int c = 0; c < 1500; c++) random_cycle(1'b1);
    for (int c = 0; c < 40; c++) random_cycle(1'b0);
    @(negedge CLK);
    #3;
    chk_en = 1'b0;
    check("rand_all_drained", 64'(exp_q.size()), 64'd0);
    check("rand_enough_wb", 64'(wb_seen >= 300), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_pipeline.md
# alu_pipeline

Parametrised two-operand integer ALU pipeline for the execution cluster, replacing the single-operand immediate pipeline. It accepts one op per cycle from the ALU issue queue with a per-op mode bit (reg-reg or reg-imm). It collects operand A and, in reg mode, operand B from PRF read ports, PRF forwarding, or the zero register. It then computes the RV32I ALU result and writes back to the PRF under backpressure.

## Interface
Parameters:
- PRF_BANK_COUNT, 4, number of PRF banks
- PRF_READ_PORTS, 2, read ports per bank
- LOG_PR_COUNT, 7, physical register index width
- LOG_ROB_ENTRIES, 7, ROB index width

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- issue_valid  in  1  op offered by IQ
- issue_is_reg  in  1  1 = B from PRF; 0 = B = sign-extended imm12
- issue_op  in  4  {funct7[5], funct3}
- issue_imm12  in  12  immediate; ignored in reg mode
- issue_A_forward / issue_B_forward  in  1 each  operand taken from forward bus
- issue_A_is_zero / issue_B_is_zero  in  1 each  operand is x0
- issue_A_bank / issue_B_bank  in  $clog2(PRF_BANK_COUNT) each  PRF bank
- issue_dest_PR  in  LOG_PR_COUNT  destination PR
- issue_ROB_index  in  LOG_ROB_ENTRIES  ROB entry
- issue_ready  out  1  pipeline accepts an issue this cycle
- A_reg_read_ack / B_reg_read_ack  in  1 each  PRF read data is valid this cycle
- A_reg_read_port / B_reg_read_port  in  $clog2(PRF_READ_PORTS) each  port carrying the data
- reg_read_data_by_bank_by_port  in  PRF_BANK_COUNT×PRF_READ_PORTS×32  read data
- forward_data_by_bank  in  PRF_BANK_COUNT×32  forward data
- WB_valid  out  1  result pending
- WB_data  out  32  result
- WB_PR  out  LOG_PR_COUNT  destination PR
- WB_ROB_index  out  LOG_ROB_ENTRIES  ROB entry
- WB_ready  in  1  PRF accepts the writeback

## Operation
- The pipeline has two register stages: OC (operand collect) and WB.
- Issue handshake: an op transfers into OC on issue_valid & issue_ready.
- issue_ready = ~OC_valid | OC_launch (combinational; no dependence on issue_valid).
- Each operand is either collected (held in a saved flag plus a 32-bit buffer) or resolved in the current cycle:
  - is_zero: resolves to 0 on the first OC cycle.
  - forward: resolves to forward_data_by_bank[bank] on the first OC cycle only.
  - otherwise: resolves to reg_read_data_by_bank_by_port[bank][port] in the cycle ack=1.
  - Reg-imm mode: operand B is always resolved from the immediate.
- Priority for a resolved value: is_zero, then forward, then ack.
- Any operand resolved this cycle but not launched is written to its buffer and its saved flag is set.
- OC_launch = OC_valid & A available (saved or resolved) & B available & (~WB_valid | WB_ready).
- On launch the WB register loads the result, dest_PR and ROB_index. The WB stage clears on WB_ready when no launch occurs.
- Operations: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
  - In imm mode, op[3] is ignored except for funct3=101; 1000 executes as ADDI.
  - Shift amount is B[4:0].
  - SLT/SLTU produce 0 or 1, zero-extended.
- An ack for an operand that is already saved, or that has is_zero/forward set, is ignored.

## Timing
- Reset values: WB_valid=0, WB_data=0, WB_PR=0, WB_ROB_index=0, OC_valid=0 (so issue_ready=1 during reset), all saved flags 0.
- Reset mid-operation discards the OC and WB contents immediately.
- Latency: issue accepted at edge t. The first OC cycle is t+1. With all operands available and no stall, WB_valid=1 in cycle t+2.
- Ack in cycle c with WB free gives WB_valid in cycle c+1.
- Throughput: 1 op/cycle with forward/zero operands and WB_ready held at 1.
- Forward data is valid only in the first OC cycle. If the op stalls that cycle on WB backpressure, the forward value is saved.
- Simultaneous events in the same cycle:
  - A and B acks together: both resolve.
  - Launch, new issue and WB_ready together: all three take effect.
- WB_data, WB_PR and WB_ROB_index are stable while WB_valid & ~WB_ready.

## Structure
- The ALU op encodings (localparams ALUOP_ADD …) and the bank/port index widths belong in core_types_pkg.
- The shared combinational sub-module is alu_core: inputs op, is_reg, A, B; output 32-bit result. It is reused by other ALU pipelines.
- All state lives in alu_pipeline.

## Test plan
- Reg-imm ADDI: A forward from bank 2 = 0x0000_0005, imm12 = 0xFFF → WB_data = 0x0000_0004 in cycle t+2.
- Reg-reg SUB: A ack on port 1 = 10 in cycle t+3, B ack on port 0 = 3 in cycle t+1 → B saved; WB_data = 7 in t+4.
- SRA reg-imm: A = 0x8000_0000 (is_zero clear, forward), imm12 = 0x41F → WB_data = 0xFFFF_FFFF. With op 0101: WB_data = 0x0000_0001.
- Backpressure: WB_ready=0 for 3 cycles with a forward operand in OC → issue_ready=0 and WB fields hold. Then WB_ready=1 → second result carries the saved forward value.
- Back-to-back: 8 zero-operand ops with WB_ready=1 → 8 consecutive WB_valid cycles with ROB_index 0–7 in order.
- RST asserted with OC and WB occupied → WB_valid=0 and issue_ready=1 in the same cycle; a stale ack arriving afterwards produces no writeback.
